regfile_wb: RTL and testbench

REGFILE_WB -- requirements
Module: regfile_wb

---
 rtl/regfile_wb.sv | 52 +++++
 tb/tb_regfile_wb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb.sv
// 32 x DATA_W register file with two combinational read ports and one write port.
// Register 0 is hard-wired to zero. Status outputs count and track committed writes.
module regfile_wb #(
    parameter int DATA_W = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [4:0]        raddr1,
    input  logic [4:0]        raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [15:0]       wr_count,
    output logic [4:0]        last_waddr
);

    logic [DATA_W-1:0] regs [32];
    logic              commit;

    // Writes to r0 are dropped here, so regs[0] stays at its reset value of zero.
    assign commit = we && (waddr != 5'd0);

    // NOTE: every entry is cleared explicitly because reads after reset must
    // return zero; a reset on the array forces flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            wr_count   <= '0;
            last_waddr <= '0;
        end else if (commit) begin
            // NOTE: non-blocking assignments so every update samples pre-edge values.
            regs[waddr] <= wdata;
            wr_count    <= wr_count + 16'd1;
            last_waddr  <= waddr;
        end
    end

    always_comb begin
        // NOTE: outputs get a default first so no path can infer a latch.
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        // Bypass is purely combinational and deliberately ignores rst.
        if (BYPASS && commit && (raddr1 == waddr)) rdata1 = wdata;
        if (BYPASS && commit && (raddr2 == waddr)) rdata2 = wdata;
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: a bypass and a non-bypass instance share
// stimulus and are compared every cycle against an array-based reference model.
module tb_regfile_wb;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;

    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic [15:0] cnt_b, cnt_n;
    logic [4:0]  last_b, last_n;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb #(.DATA_W(32), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_b), .rdata2(rd2_b),
        .wr_count(cnt_b), .last_waddr(last_b)
    );

    regfile_wb #(.DATA_W(32), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_n), .rdata2(rd2_n),
        .wr_count(cnt_n), .last_waddr(last_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain array plus integer write counter.
    logic [31:0] model_regs [32];
    int          model_count = 0;
    logic [4:0]  model_last  = '0;
    bit          model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] <= 32'd0;
            model_count <= 0;
            model_last  <= 5'd0;
            model_valid <= 1'b1;
        end else if (we && waddr != 5'd0) begin
            model_regs[waddr] <= wdata;
            model_count       <= (model_count + 1) % 65536;
            model_last        <= waddr;
        end
    end

    function automatic logic [31:0] exp_read(input logic [4:0] ra, input bit byp);
        if (byp && we && waddr != 5'd0 && ra == waddr) return wdata;
        if (ra == 5'd0) return 32'd0;
        return model_regs[ra];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            check("byp_rdata1",   rd1_b, exp_read(raddr1, 1'b1));
            check("byp_rdata2",   rd2_b, exp_read(raddr2, 1'b1));
            check("nobyp_rdata1", rd1_n, exp_read(raddr1, 1'b0));
            check("nobyp_rdata2", rd2_n, exp_read(raddr2, 1'b0));
            check("byp_wr_count",   {16'd0, cnt_b}, 32'(model_count));
            check("nobyp_wr_count", {16'd0, cnt_n}, 32'(model_count));
            check("byp_last_waddr",   {27'd0, last_b}, {27'd0, model_last});
            check("nobyp_last_waddr", {27'd0, last_n}, {27'd0, model_last});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d);
        we    = w;
        waddr = a;
        wdata = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
        do_reset();
        #1;
        check("reset_wr_count", {16'd0, cnt_b}, 32'd0);
        check("reset_last_waddr", {27'd0, last_b}, 32'd0);

        // Basic write and read-back
        drive(1'b1, 5'd5, 32'h12345678);
        step();
        drive(1'b0, 5'd0, 32'd0);
        raddr1 = 5'd5;
        #1;
        check("basic_rdata1", rd1_b, 32'h12345678);
        check("basic_wr_count", {16'd0, cnt_b}, 32'd1);
        check("basic_last_waddr", {27'd0, last_b}, 32'd5);

        // Writes to r0 are discarded and not counted
        drive(1'b1, 5'd0, 32'hFFFFFFFF);
        raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        check("r0_bypass_rdata1", rd1_b, 32'd0);
        step();
        drive(1'b0, 5'd0, 32'd0);
        #1;
        check("r0_rdata1", rd1_b, 32'd0);
        check("r0_rdata2", rd2_b, 32'd0);
        check("r0_wr_count", {16'd0, cnt_b}, 32'd1);
        check("r0_last_waddr", {27'd0, last_b}, 32'd5);

        // Same-cycle bypass vs. registered read
        do_reset();
        drive(1'b1, 5'd7, 32'hA5A5A5A5);
        raddr2 = 5'd7;
        #1;
        check("bypass_on_rdata2", rd2_b, 32'hA5A5A5A5);
        check("bypass_off_rdata2", rd2_n, 32'd0);
        step();
        drive(1'b0, 5'd0, 32'd0);
        #1;
        check("bypass_off_after_edge", rd2_n, 32'hA5A5A5A5);

        // Reset wins over a simultaneous write; bypass stays live during reset
        rst = 1'b1;
        drive(1'b1, 5'd3, 32'h1);
        raddr1 = 5'd3;
        #1;
        check("reset_cycle_bypass", rd1_b, 32'h1);
        step();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0);
        #1;
        check("rstprio_r3", rd1_b, 32'd0);
        check("rstprio_r7_cleared", rd2_b, 32'd0);
        check("rstprio_wr_count", {16'd0, cnt_b}, 32'd0);
        drive(1'b1, 5'd3, 32'h1);
        step();
        drive(1'b0, 5'd0, 32'd0);
        #1;
        check("rstprio_after_count", {16'd0, cnt_b}, 32'd1);

        // Reset in the middle of a write burst clears everything
        for (int i = 10; i < 14; i++) begin
            drive(1'b1, 5'(i), 32'hC0DE0000 + 32'(i));
            step();
        end
        do_reset();
        raddr1 = 5'd12;
        drive(1'b1, 5'd20, 32'hBEEF);
        step();
        drive(1'b0, 5'd0, 32'd0);
        #1;
        check("midreset_r12", rd1_b, 32'd0);
        check("midreset_first_count", {16'd0, cnt_b}, 32'd1);

        // Full sweep of r1..r31, then read every pairing on both ports
        do_reset();
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'(i) * 32'h01010101);
            step();
        end
        drive(1'b0, 5'd0, 32'd0);
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(31 - a);
            step();
            raddr2 = 5'(a);
            step();
        end
        raddr1 = 5'd17; raddr2 = 5'd17;
        #1;
        check("sweep_r17_p1", rd1_b, 32'h11111111);
        check("sweep_r17_p2", rd2_b, 32'h11111111);
        check("sweep_wr_count", {16'd0, cnt_b}, 32'd31);
        check("sweep_last_waddr", {27'd0, last_b}, 32'd31);

        // Counter wrap after 65536 committed writes
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 5'((i % 31) + 1), 32'(i));
            step();
        end
        drive(1'b0, 5'd0, 32'd0);
        #1;
        check("wrap_pre_count", {16'd0, cnt_b}, 32'h0000FFFF);
        drive(1'b1, 5'd9, 32'h99);
        step();
        drive(1'b0, 5'd0, 32'd0);
        #1;
        check("wrap_count", {16'd0, cnt_b}, 32'd0);
        check("wrap_last_waddr", {27'd0, last_b}, 32'd9);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
